// File: rtl/fpu_host_bridge_if.sv
// Byte-stream valid/ready bundle between the host link and fpu_host_bridge.
// master = host side, slave = bridge side.
interface fpu_host_bridge_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fpu_host_bridge.sv
// Collects two 32-bit operands from a byte stream, drives the FPU,
// waits FPU_LATENCY cycles and returns result+status as 5 bytes.
module fpu_host_bridge #(
  parameter int unsigned FPU_LATENCY = 64
) (
  input  logic        clock100KHz,
  input  logic        reset,
  fpu_host_bridge_if.slave bus,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  input  logic [31:0] fpu_data_in,
  input  logic [3:0]  fpu_status_in,
  output logic        busy
);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic [7:0] WLOAD = 8'(FPU_LATENCY - 1);

  logic [1:0]  state;
  logic [2:0]  bcnt;
  logic [2:0]  sidx;
  logic [7:0]  wcnt;
  logic [63:0] stage;
  logic [35:0] res;
  logic [63:0] nstage;
  logic        acc;
  logic        snd;

  assign acc    = bus.in_valid & bus.in_ready;
  assign snd    = bus.out_valid & bus.out_ready;
  assign nstage = {stage[55:0], bus.in_data};

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state    <= LOAD;
      bcnt     <= 3'd0;
      sidx     <= 3'd0;
      wcnt     <= 8'd0;
      stage    <= 64'd0;
      res      <= 36'd0;
      op_A_out <= 32'd0;
      op_B_out <= 32'd0;
    end else begin
      case (state)
        LOAD: begin
          if (acc) begin
            stage <= nstage;
            bcnt  <= bcnt + 3'd1;
            // FPU operands move only when a full pair is in
            if (bcnt == 3'd7) begin
              op_A_out <= nstage[63:32];
              op_B_out <= nstage[31:0];
              wcnt     <= WLOAD;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wcnt == 8'd0) begin
            res   <= {fpu_status_in, fpu_data_in};
            sidx  <= 3'd0;
            state <= SEND;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
        SEND: begin
          if (snd) begin
            if (sidx == 3'd4) begin
              sidx  <= 3'd0;
              state <= LOAD;
            end else begin
              sidx <= sidx + 3'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state == LOAD) & ~reset;
  assign bus.out_valid = (state == SEND);
  assign busy          = (state == WAIT) | (state == SEND);

  always_comb begin
    bus.out_data = 8'h00;
    if (state == SEND) begin
      case (sidx)
        3'd0:    bus.out_data = res[31:24];
        3'd1:    bus.out_data = res[23:16];
        3'd2:    bus.out_data = res[15:8];
        3'd3:    bus.out_data = res[7:0];
        3'd4:    bus.out_data = {4'b0000, res[35:32]};
        default: bus.out_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_host_bridge.sv
// Randomised self-checking bench for fpu_host_bridge with an FPU stub.
// Two instances: FPU_LATENCY=12 and FPU_LATENCY=1.
module tb_fpu_host_bridge;
  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fd  = 32'h0;
  logic [3:0]  fs  = 4'h0;
  logic [31:0] opa0, opb0, opa1, opb1;
  logic        busy0, busy1;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_host_bridge_if b0 ();
  fpu_host_bridge_if b1 ();

  fpu_host_bridge #(.FPU_LATENCY(LAT)) u0 (
    .clock100KHz(clk), .reset(rst), .bus(b0.slave),
    .op_A_out(opa0), .op_B_out(opb0),
    .fpu_data_in(fd), .fpu_status_in(fs), .busy(busy0)
  );

  fpu_host_bridge #(.FPU_LATENCY(1)) u1 (
    .clock100KHz(clk), .reset(rst), .bus(b1.slave),
    .op_A_out(opa1), .op_B_out(opb1),
    .fpu_data_in(fd), .fpu_status_in(fs), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit d, input logic v, input logic [7:0] b);
    if (d) begin b1.in_valid = v; b1.in_data = b; end
    else   begin b0.in_valid = v; b0.in_data = b; end
  endtask

  task automatic set_ordy(input bit d, input logic v);
    if (d) b1.out_ready = v;
    else   b0.out_ready = v;
  endtask

  function automatic logic iready(input bit d);
    return d ? b1.in_ready : b0.in_ready;
  endfunction

  function automatic logic ovalid(input bit d);
    return d ? b1.out_valid : b0.out_valid;
  endfunction

  function automatic logic [7:0] odata(input bit d);
    return d ? b1.out_data : b0.out_data;
  endfunction

  // expected i-th output byte: result MSB-first, then status nibble
  function automatic logic [7:0] rb(input logic [31:0] dt,
                                    input logic [3:0] st, input int i);
    logic [39:0] r;
    r = {dt, 4'b0000, st};
    return r[39-8*i -: 8];
  endfunction

  task automatic push(input bit d, input logic [7:0] b, input int gap);
    int n;
    n = 0;
    set_in(d, 1'b1, b);
    while (!iready(d) && n < LAT + 50) begin tick(); n++; end
    if (!iready(d)) begin
      checks++; failures++;
      $display("FAIL push_timeout got in_ready=0 want 1");
      set_in(d, 1'b0, 8'h00);
      return;
    end
    tick();
    set_in(d, 1'b0, 8'h00);
    repeat (gap) tick();
  endtask

  task automatic push8(input bit d, input logic [31:0] a,
                       input logic [31:0] b, input int mode);
    logic [63:0] w;
    int g;
    w = {a, b};
    for (int i = 0; i < 8; i++) begin
      g = 0;
      if (i != 7 && mode == 1) g = 1;
      if (i != 7 && mode == 2) g = int'($urandom_range(0, 2));
      push(d, w[63-8*i -: 8], g);
    end
  endtask

  task automatic pop(input bit d, input int stall,
                     input logic [7:0] exp, input string nm);
    int n;
    n = 0;
    while (!ovalid(d) && n < LAT + 50) begin tick(); n++; end
    checks++;
    if (!ovalid(d)) begin
      failures++;
      $display("FAIL %s out_valid timeout got 0 want 1", nm);
      return;
    end
    set_ordy(d, 1'b0);
    for (int i = 0; i < stall; i++) begin
      checks++;
      if (odata(d) !== exp || ovalid(d) !== 1'b1) begin
        failures++;
        $display("FAIL %s_stall got %h/%b want %h/1",
                 nm, odata(d), ovalid(d), exp);
      end
      tick();
    end
    checks++;
    if (odata(d) !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", nm, odata(d), exp);
    end
    set_ordy(d, 1'b1);
    tick();
    set_ordy(d, 1'b0);
  endtask

  task automatic drain(input bit d, input logic [31:0] dt,
                       input logic [3:0] st, input string nm);
    for (int i = 0; i < 5; i++) pop(d, 0, rb(dt, st, i), nm);
  endtask

  task automatic chk_ops(input bit d, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
    logic [31:0] ga, gb;
    ga = d ? opa1 : opa0;
    gb = d ? opb1 : opb0;
    checks++;
    if (ga !== a || gb !== b) begin
      failures++;
      $display("FAIL %s ops got %h/%h want %h/%h", nm, ga, gb, a, b);
    end
  endtask

  task automatic chk_idle(input string nm);
    checks++;
    if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b0 || busy0 !== 1'b0 ||
        b0.out_data !== 8'h00 || opa0 !== 32'h0 || opb0 !== 32'h0) begin
      failures++;
      $display("FAIL %s got rdy=%b vld=%b busy=%b od=%h a=%h b=%h want 0",
               nm, b0.in_ready, b0.out_valid, busy0, b0.out_data, opa0, opb0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    chk_idle("reset_state");
    rst = 1'b0;
    #1;
    checks++;
    if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready got %b/%b want 1/1",
               b0.in_ready, b1.in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    fd = 32'hDEADBEEF; fs = 4'h1;
    push8(0, 32'h3E000000, 32'h3E000000, 0);
    chk_ops(0, 32'h3E000000, 32'h3E000000, "basic");
    n = 0;
    while (!b0.out_valid && n < LAT + 5) begin tick(); n++; end
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL basic_latency got %0d want %0d", n, LAT);
    end
    drain(0, fd, fs, "basic_byte");
  endtask

  task automatic test_toggle();
    int n;
    fd = $urandom; fs = 4'($urandom);
    push8(0, 32'h64000064, 32'h14000064, 1);
    chk_ops(0, 32'h64000064, 32'h14000064, "toggle");
    n = 0;
    while (!b0.out_valid && n < LAT + 5) begin
      checks++;
      if (busy0 !== 1'b1) begin
        failures++;
        $display("FAIL toggle_busy_wait got %b want 1", busy0);
      end
      tick(); n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy0 !== 1'b1) begin
        failures++;
        $display("FAIL toggle_busy_send got %b want 1", busy0);
      end
      pop(0, 0, rb(fd, fs, i), "toggle_byte");
    end
    checks++;
    if (busy0 !== 1'b0) begin
      failures++;
      $display("FAIL toggle_busy_end got %b want 0", busy0);
    end
  endtask

  task automatic test_backpressure();
    fd = $urandom; fs = 4'($urandom);
    push8(0, $urandom, $urandom, 0);
    for (int i = 0; i < 5; i++)
      pop(0, (i == 2) ? 10 : 0, rb(fd, fs, i), "bp_byte");
  endtask

  task automatic test_late_change();
    fd = 32'h11111111; fs = 4'h5;
    push8(0, $urandom, $urandom, 0);
    repeat (LAT - 1) tick();
    fd = 32'h22222222;
    tick();
    fd = 32'h33333333; fs = 4'hA;
    drain(0, 32'h22222222, 4'h5, "late_byte");
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push(0, 8'($urandom), 0);
    rst = 1'b1;
    tick();
    chk_idle("midreset_state");
    rst = 1'b0;
    #1;
    fd = $urandom; fs = 4'($urandom);
    push8(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    chk_ops(0, 32'h7FFFFFFF, 32'h7FFFFFFF, "midreset_fresh");
    drain(0, fd, fs, "midreset_byte");
  endtask

  task automatic test_busy_hold();
    logic [31:0] a, b, c, e;
    int n;
    a = $urandom; b = $urandom; c = $urandom; e = $urandom;
    fd = $urandom; fs = 4'($urandom);
    push8(0, a, b, 0);
    set_in(0, 1'b1, 8'hAA);
    n = 0;
    while (!b0.out_valid && n < LAT + 5) begin
      checks++;
      if (b0.in_ready !== 1'b0 || opa0 !== a || opb0 !== b) begin
        failures++;
        $display("FAIL hold_wait got rdy=%b a=%h b=%h want 0/%h/%h",
                 b0.in_ready, opa0, opb0, a, b);
      end
      tick(); n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b0.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_send in_ready got %b want 0", b0.in_ready);
      end
      pop(0, 0, rb(fd, fs, i), "hold_byte");
    end
    set_in(0, 1'b0, 8'h00);
    fd = $urandom; fs = 4'($urandom);
    push8(0, c, e, 0);
    chk_ops(0, c, e, "hold_next");
    drain(0, fd, fs, "hold_next_byte");
  endtask

  task automatic test_lat1();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    fd = $urandom; fs = 4'($urandom);
    push8(1, a, b, 0);
    chk_ops(1, a, b, "lat1");
    checks++;
    if (b1.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat1_early out_valid got %b want 0", b1.out_valid);
    end
    tick();
    checks++;
    if (b1.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL lat1_capture out_valid got %b want 1", b1.out_valid);
    end
    drain(1, fd, fs, "lat1_byte");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int k = 0; k < 20; k++) begin
      a = $urandom; b = $urandom;
      fd = $urandom; fs = 4'($urandom);
      push8(0, a, b, 2);
      chk_ops(0, a, b, "rand");
      for (int i = 0; i < 5; i++)
        pop(0, int'($urandom_range(0, 3)), rb(fd, fs, i), "rand_byte");
    end
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.in_data = 8'h00; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_backpressure();
    test_late_change();
    test_mid_reset();
    test_busy_hold();
    test_lat1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_host_bridge.md
# fpu_host_bridge

Byte-stream front end for the `fpu` datapath. It collects two 32-bit operands from an 8-bit valid/ready input stream and presents them to the FPU's `op_A_in`/`op_B_in`. It waits a fixed number of cycles for the FPU to settle, captures `data_out`/`status_out`, and returns the result as a 5-byte valid/ready output stream. It sits between the host link and `fpu`, driving the FPU operand inputs and consuming its result outputs.

## Interface
- FPU_LATENCY, default 64: cycles from operand update to result capture; legal range 1..255.
- clock100KHz  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  bridge accepts a byte; a byte transfers on a rising edge with in_valid & in_ready.
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts a byte; a byte transfers on a rising edge with out_valid & out_ready.
- op_A_out  out  32  to fpu.op_A_in; format {sign, exp[5:0], mant[24:0]}.
- op_B_out  out  32  to fpu.op_B_in.
- fpu_data_in  in  32  from fpu.data_out.
- fpu_status_in  in  4  from fpu.status_out.
- busy  out  1  high in WAIT and SEND.

## Operation
- FSM states:
  - LOAD (reset state): in_ready=1, out_valid=0. A 3-bit byte counter advances on each accepted byte. Bytes arrive MSB-first: bytes 0-3 form A[31:24]..A[7:0], bytes 4-7 form B[31:24]..B[7:0], assembled into a 64-bit staging register. On acceptance of byte 7, op_A_out/op_B_out load from staging in the same edge, the wait counter loads FPU_LATENCY-1, and the FSM enters WAIT.
  - WAIT: in_ready=0. The counter decrements each cycle. On the cycle the counter is 0, fpu_data_in and fpu_status_in are captured into the result register, the send counter clears, and the FSM enters SEND.
  - SEND: out_valid=1. out_data by send index: 0 → res[31:24], 1 → res[23:16], 2 → res[15:8], 3 → res[7:0], 4 → {4'b0000, status}. The index advances only on handshake. out_data and out_valid stay stable while out_ready=0. The handshake on index 4 returns the FSM to LOAD.
- op_A_out/op_B_out change only on acceptance of byte 7, so FPU inputs stay stable through WAIT, SEND and the next LOAD until the next operand pair is complete.
- Bytes offered by the host while not in LOAD are not accepted. in_data is ignored whenever in_valid=0.
- No back-to-back overlap: a new operand load starts only after the 5th result byte transfers.
- Status nibble is passed through unmodified. The bridge assigns no meaning to it.

## Timing
- Reset values, applied on an edge with reset=1:
  - state=LOAD; byte, send and wait counters=0; staging, result, op_A_out, op_B_out=0.
  - out_valid=0, busy=0, out_data=0.
  - in_ready=0 while reset is high; in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation, in any state: discard partial operands and any pending result; no further out bytes are emitted.
- Byte 7 accepted at edge k: op_*_out are new after edge k. Result is captured at edge k+FPU_LATENCY. out_valid=1 after that edge.
- FPU_LATENCY=1: capture occurs at the edge immediately after byte 7.
- Throughput: 8 input cycles + FPU_LATENCY + 5 output cycles minimum per operation, with no stalls.
- in_valid and out_ready may toggle every cycle; stalls of any length must not drop or duplicate bytes.

## Test plan
- Reset, then stream bytes 3E 00 00 00 3E 00 00 00 with in_valid held high. Required:
  - op_A_out=op_B_out=0x3E000000 after the 8th edge.
  - With the FPU stub driving 0xDEADBEEF / 4'h1, output is DE AD BE EF 01.
  - out_valid rises exactly FPU_LATENCY cycles after byte 7.
- Operands 0x6400_0064 and 0x1400_0064, with in_valid toggling 1/0 each cycle. Required: same assembled operands, no skipped bytes, and busy high from byte 7 until the last output byte.
- Back-pressure: hold out_ready=0 for 10 cycles mid-SEND at index 2. Required: out_data stays at res[15:8] with out_valid=1, and the sequence resumes with no duplication.
- Stub changes fpu_data_in from 0x11111111 to 0x22222222 one cycle before capture. Required: 0x22222222 is returned. A change after capture does not alter the emitted bytes.
- Assert reset after 5 input bytes. Required:
  - All outputs return to reset values.
  - A fresh 8-byte load of 0x7FFFFFFF / 0x7FFFFFFF yields op_*_out=0x7FFFFFFF with no residue from the aborted load.
- Hold in_valid=1 during WAIT and SEND. Required: in_ready=0 and no staging change; the next operation starts only after the 5th output handshake.
